// File: rtl/melody_pkg.sv
// Shared types and helpers for the melody sequencer: ROM entry layout,
// sequencer state encoding and the note-to-key decoder.
package melody_pkg;

  localparam int NOTE_W  = 4;
  localparam int DUR_W   = 3;
  localparam int ENTRY_W = NOTE_W + DUR_W;

  localparam logic [DUR_W-1:0] END_MARK = 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_NOTE = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Notes 1..8 select key bits 0..7; everything else is a rest.
  function automatic logic [7:0] decode_note(input logic [NOTE_W-1:0] note);
    logic [7:0] key_s;
    key_s = 8'h00;
    case (note)
      4'd1:    key_s = 8'h01;
      4'd2:    key_s = 8'h02;
      4'd3:    key_s = 8'h04;
      4'd4:    key_s = 8'h08;
      4'd5:    key_s = 8'h10;
      4'd6:    key_s = 8'h20;
      4'd7:    key_s = 8'h40;
      4'd8:    key_s = 8'h80;
      default: key_s = 8'h00;
    endcase
    return key_s;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control and key-bus bundle between the player front end and the sequencer.
interface melody_sequencer_if;
  logic       play;
  logic       stop;
  logic       loop_en;
  logic [7:0] manual_keys;
  logic [7:0] keys;
  logic       busy;
  logic       done;

  modport master (
    output play, stop, loop_en, manual_keys,
    input  keys, busy, done
  );

  modport slave (
    input  play, stop, loop_en, manual_keys,
    output keys, busy, done
  );
endinterface

// File: rtl/melody_rom.sv
// Combinational melody store; each entry is {note[3:0], dur[2:0]}.
// Unlisted addresses read as zero, which is the end-of-song marker.
module melody_rom
  import melody_pkg::*;
#(
  parameter int SONG_SEL = 0,
  parameter int ADDR_W   = 6
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] entry
);

  // Song table lookup selected at elaboration time by SONG_SEL.
  always_comb begin
    entry = 7'd0;
    if (SONG_SEL == 0) begin
      case (32'(addr))
        32'd0:   entry = {4'd1, 3'd2};
        32'd1:   entry = {4'd3, 3'd1};
        32'd2:   entry = {4'd0, 3'd1};
        32'd3:   entry = {4'd8, 3'd1};
        default: entry = {4'd0, END_MARK};
      endcase
    end else begin
      // Opening phrase of Ode to Joy, C major (C=1 .. C'=8).
      case (32'(addr))
        32'd0:   entry = {4'd3, 3'd1};
        32'd1:   entry = {4'd3, 3'd1};
        32'd2:   entry = {4'd4, 3'd1};
        32'd3:   entry = {4'd5, 3'd1};
        32'd4:   entry = {4'd5, 3'd1};
        32'd5:   entry = {4'd4, 3'd1};
        32'd6:   entry = {4'd3, 3'd1};
        32'd7:   entry = {4'd2, 3'd1};
        32'd8:   entry = {4'd1, 3'd1};
        32'd9:   entry = {4'd1, 3'd1};
        32'd10:  entry = {4'd2, 3'd1};
        32'd11:  entry = {4'd3, 3'd1};
        32'd12:  entry = {4'd3, 3'd2};
        32'd13:  entry = {4'd2, 3'd1};
        32'd14:  entry = {4'd2, 3'd3};
        default: entry = {4'd0, END_MARK};
      endcase
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Auto-play source for the piano tone stage: walks melody_rom and drives a
// one-hot key bus with timed notes and articulation gaps, else passes the keypad.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int BEAT_TICKS = 250000,
  parameter int GAP_TICKS  = 20000,
  parameter int SONG_LEN   = 32,
  parameter int SONG_SEL   = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  melody_sequencer_if.slave   bus
);

  localparam int CNT_W  = $clog2(7 * BEAT_TICKS);
  localparam int ADDR_W = $clog2(SONG_LEN + 1);

  state_t             state_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [7:0]         seq_keys_r;
  logic               busy_r;
  logic               done_r;

  logic [ENTRY_W-1:0] entry_s;
  logic [NOTE_W-1:0]  note_s;
  logic [DUR_W-1:0]   dur_s;
  logic               song_end_s;
  logic               cnt_zero_s;

  melody_rom #(
    .SONG_SEL (SONG_SEL),
    .ADDR_W   (ADDR_W)
  ) u_rom (
    .addr  (addr_r),
    .entry (entry_s)
  );

  assign note_s     = entry_s[ENTRY_W-1:DUR_W];
  assign dur_s      = entry_s[DUR_W-1:0];
  assign song_end_s = (dur_s == END_MARK) || (addr_r == ADDR_W'(SONG_LEN));
  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});

  assign bus.keys = busy_r ? seq_keys_r : bus.manual_keys;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // Sequencer FSM: note/gap timing, ROM addressing and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      seq_keys_r <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state_r != ST_IDLE && bus.stop) begin
        // Abort wins over everything, including a pending DONE.
        state_r    <= ST_IDLE;
        addr_r     <= {ADDR_W{1'b0}};
        cnt_r      <= {CNT_W{1'b0}};
        seq_keys_r <= 8'h00;
        busy_r     <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.play && !bus.stop) begin
              state_r <= ST_LOAD;
              addr_r  <= {ADDR_W{1'b0}};
              busy_r  <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (song_end_s) begin
              seq_keys_r <= 8'h00;
              if (addr_r != {ADDR_W{1'b0}} && bus.loop_en) begin
                addr_r <= {ADDR_W{1'b0}};
              end else begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end
            end else begin
              seq_keys_r <= decode_note(note_s);
              cnt_r      <= CNT_W'(int'(dur_s) * BEAT_TICKS - GAP_TICKS - 1);
              state_r    <= ST_NOTE;
            end
          end
          ST_NOTE: begin
            if (cnt_zero_s) begin
              seq_keys_r <= 8'h00;
              cnt_r      <= CNT_W'(GAP_TICKS - 1);
              state_r    <= ST_GAP;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (cnt_zero_s) begin
              addr_r  <= addr_r + ADDR_W'(1);
              state_r <= ST_LOAD;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r    <= ST_IDLE;
            seq_keys_r <= 8'h00;
            busy_r     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
